conv_output_streamer: RTL and testbench

Serialises the flat convolution-stage result vector (DEPTH×DATA_WIDTH bits, 120 words by default) into a word-at-a-time stream with valid/ready flow control. It sits at the output of the convolution integration, on the consumer side of its wide `iConvOutput` bus. It feeds narrow downstream logic: the fully-connected stage loader, a debug port or a host FIFO. It snapshots the bus on a load strobe, so upstream may change the bus immediately afterwards.

---
 rtl/conv_output_streamer_if.sv | 19 +
 rtl/conv_output_streamer.sv | 140 ++++++++++++++
 tb/tb_conv_output_streamer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_output_streamer_if.sv
`default_nettype none
// ============================================================================
// Module  : conv_output_streamer_if
// Brief   : Word-stream bus (data/valid/ready/last) between the convolution
//           output streamer and its narrow consumer.
// Revision: 1.0 - initial release
// ============================================================================
interface conv_output_streamer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] outData;
  logic                  outValid;
  logic                  outReady;
  logic                  outLast;

  modport master (output outData, output outValid, output outLast, input outReady);
  modport slave  (input outData, input outValid, input outLast, output outReady);
endinterface
`default_nettype wire

// File: rtl/conv_output_streamer.sv
`default_nettype none
// ============================================================================
// Module  : conv_output_streamer
// Brief   : Snapshots the flat DEPTH x DATA_WIDTH convolution result on a
//           load strobe and streams it one word per handshake.
//           Optional feature macro: STREAM_CHECKSUM_EN appends a modulo
//           2^DATA_WIDTH sum of the frame as a trailing word.
// Revision: 1.0 - initial release
// ============================================================================
module conv_output_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 120
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DEPTH*DATA_WIDTH-1:0] convIn,
  input  logic                        load,
  conv_output_streamer_if.master      strm,
  output logic                        busy,
  output logic                        overrun
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

`ifdef STREAM_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, SUM = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1} state_t;
`endif

  state_t                              state;
  state_t                              state_nxt;
  logic [IDX_W-1:0]                    idx;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    shadow;
  logic                                hs;
  logic                                at_last;
  logic                                capture;
  logic                                advance;
  logic                                load_ignored;
`ifdef STREAM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]               acc;
`endif

  // Handshake qualifier derived from registered state so valid never depends on ready
  assign hs      = (state != IDLE) && strm.outReady;
  assign at_last = (idx == LAST_IDX);
  assign busy    = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and stream outputs
  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    advance       = 1'b0;
    load_ignored  = 1'b0;
    strm.outData  = '0;
    strm.outValid = 1'b0;
    strm.outLast  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        strm.outData  = shadow[idx];
        strm.outValid = 1'b1;
`ifndef STREAM_CHECKSUM_EN
        strm.outLast  = at_last;
`endif
        if (hs) begin
          if (at_last) begin
`ifdef STREAM_CHECKSUM_EN
            state_nxt = SUM;
`else
            // A load coinciding with the final handshake starts the next frame seamlessly
            if (load) capture = 1'b1;
            else      state_nxt = IDLE;
`endif
          end else begin
            advance = 1'b1;
          end
        end
        if (load && !capture) load_ignored = 1'b1;
      end
`ifdef STREAM_CHECKSUM_EN
      SUM: begin
        strm.outData  = acc;
        strm.outValid = 1'b1;
        strm.outLast  = 1'b1;
        if (hs) begin
          if (load) begin
            capture   = 1'b1;
            state_nxt = STREAM;
          end else begin
            state_nxt = IDLE;
          end
        end
        if (load && !capture) load_ignored = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow capture, word index and sticky overrun flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow  <= '0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      if (capture) begin
        shadow <= convIn;
        idx    <= '0;
      end else if (advance) begin
        idx <= idx + 1'b1;
      end
      if (load_ignored) overrun <= 1'b1;
    end
  end

`ifdef STREAM_CHECKSUM_EN
  // Running sum of every word accepted during STREAM, restarted on each capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        acc <= '0;
    else if (capture)                  acc <= '0;
    else if (hs && (state == STREAM))  acc <= acc + shadow[idx];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_output_streamer.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_output_streamer
// Brief   : Directed self-checking bench for conv_output_streamer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_conv_output_streamer;

  localparam int DW    = 16;
  localparam int DEPTH = 120;
`ifdef STREAM_CHECKSUM_EN
  localparam int FRAME_LEN = DEPTH + 1;
`else
  localparam int FRAME_LEN = DEPTH;
`endif

  logic                  clk    = 1'b0;
  logic                  reset  = 1'b0;
  logic                  load   = 1'b0;
  logic [DEPTH*DW-1:0]   convIn = '0;
  logic                  busy;
  logic                  overrun;

  conv_output_streamer_if #(.DATA_WIDTH(DW)) strm ();

  conv_output_streamer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .convIn  (convIn),
    .load    (load),
    .strm    (strm),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_d[$];
  logic          exp_l[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < DEPTH; i++) convIn[i*DW +: DW] = DW'(i + 1);
  endtask

  task automatic set_fill(input logic [DW-1:0] v);
    for (int i = 0; i < DEPTH; i++) convIn[i*DW +: DW] = v;
  endtask

  // Expected frame: word i = i+1 (ramp) or constant fill, plus optional sum word
  task automatic push_frame(input bit ramp, input logic [DW-1:0] v);
    logic [DW-1:0] sum = '0;
    logic [DW-1:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = ramp ? DW'(i + 1) : v;
      sum = sum + w;
      exp_d.push_back(w);
`ifdef STREAM_CHECKSUM_EN
      exp_l.push_back(1'b0);
`else
      exp_l.push_back(i == DEPTH - 1);
`endif
    end
`ifdef STREAM_CHECKSUM_EN
    exp_d.push_back(sum);
    exp_l.push_back(1'b1);
`endif
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Consume the expected queue; called #1 after an edge, returns #1 after an edge
  task automatic collect(input bit bp, input int load_at, input logic [DW-1:0] load_fill,
                         output int cycles);
    int            got   = 0;
    int            cyc   = 0;
    int            total = exp_d.size();
    bit            fired = 1'b0;
    bit            stalled = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic          held_l = 1'b0;
    while (got < total && cyc < 4 * total + 20) begin
      strm.outReady = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (got == load_at && !fired) begin
        set_fill(load_fill);
        load  = 1'b1;
        fired = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      if (stalled) begin
        chk("hold_valid", 32'(strm.outValid), 32'd1);
        chk("hold_data", 32'(strm.outData), 32'(held_d));
        chk("hold_last", 32'(strm.outLast), 32'(held_l));
      end
      stalled = 1'b0;
      if (strm.outValid && strm.outReady) begin
        chk($sformatf("data[%0d]", got), 32'(strm.outData), 32'(exp_d[got]));
        chk($sformatf("last[%0d]", got), 32'(strm.outLast), 32'(exp_l[got]));
        got++;
      end else if (strm.outValid) begin
        stalled = 1'b1;
        held_d  = strm.outData;
        held_l  = strm.outLast;
      end
      @(posedge clk); #1;
      cyc++;
    end
    load = 1'b0;
    chk("words_received", 32'(got), 32'(total));
    cycles = cyc;
    exp_d.delete();
    exp_l.delete();
  endtask

  initial begin
    int cyc;
    strm.outReady = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(strm.outData), 32'd0);
    chk("rst_valid", 32'(strm.outValid), 32'd0);
    chk("rst_last", 32'(strm.outLast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", 32'(strm.outValid), 32'd0);

    // Basic frame, consumer always ready
    set_ramp();
    push_frame(1'b1, '0);
    pulse_load();
    chk("lat_valid", 32'(strm.outValid), 32'd1);
    chk("lat_data", 32'(strm.outData), 32'd1);
    chk("lat_busy", 32'(busy), 32'd1);
    collect(1'b0, -1, '0, cyc);
    chk("basic_cycles", 32'(cyc), 32'(FRAME_LEN));
    chk("basic_busy_end", 32'(busy), 32'd0);
    chk("basic_valid_end", 32'(strm.outValid), 32'd0);

    // Backpressure 1,0,0,1 with bus changed right after the load
    set_ramp();
    push_frame(1'b1, '0);
    pulse_load();
    set_fill(16'hFFFF);
    collect(1'b1, -1, '0, cyc);
    chk("bp_busy_end", 32'(busy), 32'd0);

    // Back-to-back frames, second load on the final handshake
    set_ramp();
    push_frame(1'b1, '0);
    push_frame(1'b0, 16'hA5A5);
    pulse_load();
    collect(1'b0, FRAME_LEN - 1, 16'hA5A5, cyc);
    chk("b2b_cycles", 32'(cyc), 32'(2 * FRAME_LEN));
    chk("b2b_overrun", 32'(overrun), 32'd0);
    chk("b2b_busy_end", 32'(busy), 32'd0);

    // Overrun: ignored load at word index 50
    set_ramp();
    push_frame(1'b1, '0);
    pulse_load();
    collect(1'b0, 50, 16'hFFFF, cyc);
    chk("ovr_cycles", 32'(cyc), 32'(FRAME_LEN));
    chk("ovr_flag", 32'(overrun), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset asserted mid-frame at word index 30
    set_ramp();
    pulse_load();
    strm.outReady = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("pre_rst_data", 32'(strm.outData), 32'd31);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_data", 32'(strm.outData), 32'd0);
    chk("mid_rst_valid", 32'(strm.outValid), 32'd0);
    chk("mid_rst_last", 32'(strm.outLast), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(strm.outValid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    set_ramp();
    push_frame(1'b1, '0);
    pulse_load();
    collect(1'b0, -1, '0, cyc);
    chk("post_rst_cycles", 32'(cyc), 32'(FRAME_LEN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
